// File: rtl/rv0_ahb_sram.sv
// AHB-Lite responder SRAM: fixed wait states, byte-strobed writes, read-after-write bypass.
// Define RV0_AHB_SRAM_PARITY_EN to store one even-parity bit per byte and flag corrupt reads.
module rv0_ahb_sram #(
    parameter int              XLEN        = 32,
    parameter int              DEPTH       = 1024,
    parameter int              WAIT_CYCLES = 0,
    parameter logic [XLEN-1:0] BASE_ADDR   = '0
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic [XLEN-1:0]   haddr,
    input  logic [2:0]        hsize,
    input  logic [1:0]        htrans,
    input  logic [2:0]        hburst,
    input  logic              hwrite,
    input  logic [XLEN-1:0]   hwdata,
    input  logic [XLEN/8-1:0] hwstrb,
    input  logic              hsel,
    input  logic              hready,
    output logic [XLEN-1:0]   hrdata,
    output logic              hreadyout,
    output logic              hresp
);
    localparam int NB  = XLEN / 8;
    localparam int NBL = $clog2(NB);
    localparam int AW  = $clog2(DEPTH);
    localparam logic [XLEN-1:0] SPAN    = XLEN'(DEPTH * NB);
    localparam logic [3:0]      WAIT_LD = 4'(WAIT_CYCLES);

    typedef enum logic [2:0] {S_IDLE, S_WAIT, S_DATA, S_ERR1, S_ERR2} state_e;

    state_e          state_q, state_d;
    logic [3:0]      cnt_q, cnt_d;
    logic [AW-1:0]   lat_idx_q;
    logic            lat_wr_q;
    logic            acc, ld_rd, wr_en, hit, err_a, par_err;
    logic [XLEN-1:0] off, rd_word;
    logic [AW-1:0]   idx_a, rd_idx;
    logic [XLEN-1:0] mem [DEPTH];
    logic            unused;

    // Address below BASE_ADDR wraps to a huge offset and is caught by the range check.
    assign off    = haddr - BASE_ADDR;
    assign idx_a  = off[AW+NBL-1:NBL];
    assign err_a  = (off >= SPAN) || (int'(hsize) > NBL) ||
                    (|(haddr & ~({XLEN{1'b1}} << hsize)));
    assign unused = ^hburst;

    assign rd_idx = (state_q == S_WAIT) ? lat_idx_q : idx_a;
    assign wr_en  = (state_q == S_DATA) && lat_wr_q;
    assign hit    = wr_en && (lat_idx_q == rd_idx);

    // A read launched during a write's final cycle sees the bytes being written.
    always_comb begin
        rd_word = mem[rd_idx];
        for (int i = 0; i < NB; i++)
            if (hit && hwstrb[i]) rd_word[8*i +: 8] = hwdata[8*i +: 8];
    end

`ifdef RV0_AHB_SRAM_PARITY_EN
    logic [NB-1:0] par_mem [DEPTH];
    logic [NB-1:0] rd_par, calc_par;

    always_comb begin
        rd_par   = par_mem[rd_idx];
        calc_par = '0;
        for (int i = 0; i < NB; i++) begin
            if (hit && hwstrb[i]) rd_par[i] = ^hwdata[8*i +: 8];
            calc_par[i] = ^rd_word[8*i +: 8];
        end
    end
    assign par_err = |(rd_par ^ calc_par);

    always_ff @(posedge clk_i) begin
        for (int i = 0; i < NB; i++)
            if (wr_en && hwstrb[i]) par_mem[lat_idx_q][i] <= ^hwdata[8*i +: 8];
    end
`else
    assign par_err = 1'b0;
`endif

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        ld_rd     = 1'b0;
        hreadyout = 1'b1;
        hresp     = 1'b0;
        acc       = 1'b0;
        case (state_q)
            S_WAIT: begin
                hreadyout = 1'b0;
                if (cnt_q == 4'd1) begin
                    ld_rd   = !lat_wr_q;
                    state_d = (!lat_wr_q && par_err) ? S_ERR1 : S_DATA;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            S_ERR1: begin
                hreadyout = 1'b0;
                hresp     = 1'b1;
                state_d   = S_ERR2;
            end
            S_ERR2: begin
                hresp   = 1'b1;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
        // New address phase overlaps the final data cycle of the previous transfer.
        acc = hsel && hready && htrans[1] && hreadyout;
        if (acc) begin
            if (err_a) begin
                state_d = S_ERR1;
            end else if (WAIT_CYCLES > 0) begin
                state_d = S_WAIT;
                cnt_d   = WAIT_LD;
            end else if (!hwrite) begin
                ld_rd   = 1'b1;
                state_d = par_err ? S_ERR1 : S_DATA;
            end else begin
                state_d = S_DATA;
            end
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) state_q <= S_IDLE;
        else       state_q <= state_d;
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            cnt_q     <= '0;
            lat_idx_q <= '0;
            lat_wr_q  <= 1'b0;
            hrdata    <= '0;
        end else begin
            cnt_q <= cnt_d;
            if (acc) begin
                lat_idx_q <= idx_a;
                lat_wr_q  <= hwrite;
            end
            if (ld_rd) hrdata <= rd_word;
        end
    end

    always_ff @(posedge clk_i) begin
        for (int i = 0; i < NB; i++)
            if (wr_en && hwstrb[i]) mem[lat_idx_q][8*i +: 8] <= hwdata[8*i +: 8];
    end
endmodule

// File: tb/tb_rv0_ahb_sram.sv
// Randomized bench for rv0_ahb_sram: a zero-wait and a two-wait instance against a byte-array model.
module tb_rv0_ahb_sram;
    localparam int          DEPTH = 256;
    localparam logic [31:0] BASE1 = 32'h2000;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [31:0] haddr  [2];
    logic [2:0]  hsize  [2];
    logic [1:0]  htrans [2];
    logic [2:0]  hburst [2];
    logic        hwrite [2];
    logic [31:0] hwdata [2];
    logic [3:0]  hwstrb [2];
    logic        hsel   [2];
    logic [31:0] hrdata [2];
    logic        hreadyout [2];
    logic        hresp  [2];

    logic [31:0] mdl [2][DEPTH];
    logic [31:0] last_rd [2];
    int vectors = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    rv0_ahb_sram #(.XLEN(32), .DEPTH(DEPTH), .WAIT_CYCLES(0), .BASE_ADDR(32'h0)) u_dut0 (
        .clk_i(clk), .rst_i(rst), .haddr(haddr[0]), .hsize(hsize[0]), .htrans(htrans[0]),
        .hburst(hburst[0]), .hwrite(hwrite[0]), .hwdata(hwdata[0]), .hwstrb(hwstrb[0]),
        .hsel(hsel[0]), .hready(hreadyout[0]), .hrdata(hrdata[0]), .hreadyout(hreadyout[0]),
        .hresp(hresp[0]));

    rv0_ahb_sram #(.XLEN(32), .DEPTH(DEPTH), .WAIT_CYCLES(2), .BASE_ADDR(BASE1)) u_dut1 (
        .clk_i(clk), .rst_i(rst), .haddr(haddr[1]), .hsize(hsize[1]), .htrans(htrans[1]),
        .hburst(hburst[1]), .hwrite(hwrite[1]), .hwdata(hwdata[1]), .hwstrb(hwstrb[1]),
        .hsel(hsel[1]), .hready(hreadyout[1]), .hrdata(hrdata[1]), .hreadyout(hreadyout[1]),
        .hresp(hresp[1]));

    function automatic int wt(input int b);
        return (b == 1) ? 2 : 0;
    endfunction

    function automatic logic [31:0] base_of(input int b);
        return (b == 1) ? BASE1 : 32'h0;
    endfunction

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // One isolated transfer; returns hrdata/hresp from the cycle hreadyout goes high.
    task automatic xfer(input int b, input logic [31:0] a, input logic [2:0] sz, input logic wr,
                        input logic [31:0] wd, input logic [3:0] st,
                        output logic [31:0] rd, output logic err, output logic e1, output int waits);
        haddr[b] = a; hsize[b] = sz; hwrite[b] = wr; htrans[b] = 2'b10; hsel[b] = 1'b1;
        @(posedge clk); #1;
        htrans[b] = 2'b00; hsel[b] = 1'b0; hwdata[b] = wd; hwstrb[b] = st;
        waits = 0;
        e1 = hresp[b];
        while (!hreadyout[b] && waits < 20) begin @(posedge clk); #1; waits++; end
        err = hresp[b];
        rd  = hrdata[b];
        @(posedge clk); #1;
    endtask

    task automatic do_op(input int b, input logic [31:0] a, input logic [2:0] sz, input logic wr,
                         input logic [31:0] wd, input logic [3:0] st, output logic [31:0] rd);
        logic [31:0] off;
        logic        exp_err, err, e1;
        int          waits, w;
        off     = a - base_of(b);
        exp_err = (off >= 32'(DEPTH * 4)) || (sz > 3'd2) || ((a % (32'd1 << sz)) != 0);
        w       = int'(off >> 2);
        xfer(b, a, sz, wr, wd, st, rd, err, e1, waits);
        chk("resp", 32'(err), 32'(exp_err));
        chk("waits", 32'(waits), 32'(exp_err ? 1 : wt(b)));
        if (exp_err) chk("err_first", 32'(e1), 32'd1);
        if (!exp_err && wr)
            for (int i = 0; i < 4; i++)
                if (st[i]) mdl[b][w][8*i +: 8] = wd[8*i +: 8];
        if (!exp_err && !wr) begin
            last_rd[b] = mdl[b][w];
            chk("rdata", rd, last_rd[b]);
        end else begin
            chk("rdata_hold", rd, last_rd[b]);
        end
    endtask

    // Write followed by a read whose address phase sits in the write's final data cycle.
    task automatic pipe(input int b, input logic [31:0] wa, input logic [31:0] wd,
                        input logic [3:0] st, input logic [31:0] ra, output logic [31:0] rd);
        int n, wo, ro;
        wo = int'((wa - base_of(b)) >> 2);
        ro = int'((ra - base_of(b)) >> 2);
        haddr[b] = wa; hsize[b] = 3'd2; hwrite[b] = 1'b1; htrans[b] = 2'b10; hsel[b] = 1'b1;
        @(posedge clk); #1;
        htrans[b] = 2'b00; hsel[b] = 1'b0; hwdata[b] = wd; hwstrb[b] = st;
        n = 0;
        while (!hreadyout[b] && n < 20) begin @(posedge clk); #1; n++; end
        chk("pipe_wr_waits", 32'(n), 32'(wt(b)));
        haddr[b] = ra; hwrite[b] = 1'b0; htrans[b] = 2'b10; hsel[b] = 1'b1;
        @(posedge clk); #1;
        htrans[b] = 2'b00; hsel[b] = 1'b0;
        for (int i = 0; i < 4; i++)
            if (st[i]) mdl[b][wo][8*i +: 8] = wd[8*i +: 8];
        n = 0;
        while (!hreadyout[b] && n < 20) begin @(posedge clk); #1; n++; end
        chk("pipe_rd_waits", 32'(n), 32'(wt(b)));
        chk("pipe_rd_resp", 32'(hresp[b]), 32'd0);
        last_rd[b] = mdl[b][ro];
        rd = hrdata[b];
        chk("pipe_rd_data", rd, last_rd[b]);
        @(posedge clk); #1;
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog expired");
        $fatal(1);
    end

    initial begin
        logic [31:0] rd, a;
        logic        err, e1;
        int          waits, r, word, lane;
        logic [2:0]  sz;

        for (int b = 0; b < 2; b++) begin
            haddr[b] = '0; hsize[b] = '0; htrans[b] = '0; hburst[b] = 3'b001;
            hwrite[b] = 1'b0; hwdata[b] = '0; hwstrb[b] = '0; hsel[b] = 1'b0;
            last_rd[b] = '0;
        end
        #2 rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        for (int b = 0; b < 2; b++) begin
            chk("rst_hreadyout", 32'(hreadyout[b]), 32'd1);
            chk("rst_hresp", 32'(hresp[b]), 32'd0);
            chk("rst_hrdata", hrdata[b], 32'd0);
        end
        rst = 1'b0;

        for (int b = 0; b < 2; b++)
            for (int w = 0; w < DEPTH; w++)
                do_op(b, base_of(b) + 32'(w * 4), 3'd2, 1'b1, $urandom, 4'hF, rd);

        do_op(0, 32'h100, 3'd2, 1'b1, 32'hDEADBEEF, 4'hF, rd);
        do_op(0, 32'h100, 3'd2, 1'b0, 32'h0, 4'h0, rd);
        chk("word_rd", rd, 32'hDEADBEEF);
        do_op(0, 32'h101, 3'd0, 1'b1, 32'h0000AA00, 4'b0010, rd);
        do_op(0, 32'h100, 3'd2, 1'b0, 32'h0, 4'h0, rd);
        chk("byte_merge", rd, 32'hDEADAAEF);
        do_op(1, BASE1 + 32'h40, 3'd2, 1'b0, 32'h0, 4'h0, rd);
        do_op(0, 32'(DEPTH * 4), 3'd2, 1'b1, 32'hFFFFFFFF, 4'hF, rd);
        do_op(0, 32'h0, 3'd2, 1'b0, 32'h0, 4'h0, rd);
        do_op(0, 32'h102, 3'd2, 1'b1, 32'hFFFFFFFF, 4'hF, rd);
        do_op(0, 32'h100, 3'd2, 1'b0, 32'h0, 4'h0, rd);
        chk("misalign_nowr", rd, 32'hDEADAAEF);
        pipe(0, 32'h8, 32'h12345678, 4'hF, 32'h8, rd);
        chk("raw_bypass", rd, 32'h12345678);
        do_op(1, BASE1 - 32'h4, 3'd2, 1'b1, 32'h0, 4'hF, rd);

        for (int k = 0; k < 300; k++) begin
            for (int b = 0; b < 2; b++) begin
                r    = $urandom_range(0, 99);
                word = $urandom_range(0, DEPTH - 1);
                sz   = 3'($urandom_range(0, 2));
                lane = $urandom_range(0, 3) & ~((1 << sz) - 1);
                a    = base_of(b) + 32'(word * 4 + lane);
                if (r < 8) begin
                    sz = 3'($urandom_range(1, 2));
                    a  = base_of(b) + 32'(word * 4 + 1);
                end else if (r < 16) begin
                    sz = 3'd2;
                    if (b == 1 && r < 12) a = base_of(b) - 32'(4 * $urandom_range(1, 64));
                    else a = base_of(b) + 32'(DEPTH * 4 + 4 * $urandom_range(0, 255));
                end else if (r < 20) begin
                    sz = 3'd3;
                    a  = base_of(b) + 32'((word & ~1) * 4);
                end
                if (r >= 20 && r < 35) begin
                    pipe(b, base_of(b) + 32'(word * 4), $urandom, 4'($urandom_range(0, 15)),
                         (r < 28) ? base_of(b) + 32'(word * 4)
                                  : base_of(b) + 32'(4 * $urandom_range(0, DEPTH - 1)), rd);
                end else begin
                    do_op(b, a, sz, 1'($urandom_range(0, 1)), $urandom,
                          4'($urandom_range(0, 15)), rd);
                end
            end
        end

        haddr[1] = BASE1 + 32'h80; hsize[1] = 3'd2; hwrite[1] = 1'b1;
        htrans[1] = 2'b10; hsel[1] = 1'b1;
        @(posedge clk); #1;
        htrans[1] = 2'b00; hsel[1] = 1'b0; hwdata[1] = 32'h55AA55AA; hwstrb[1] = 4'hF;
        chk("wait_entry", 32'(hreadyout[1]), 32'd0);
        rst = 1'b1;
        #1;
        chk("rst_mid_rdy", 32'(hreadyout[1]), 32'd1);
        chk("rst_mid_resp", 32'(hresp[1]), 32'd0);
        chk("rst_mid_rdata", hrdata[1], 32'd0);
        last_rd[0] = '0;
        last_rd[1] = '0;
        @(posedge clk); #1;
        rst = 1'b0;
        do_op(1, BASE1 + 32'h80, 3'd2, 1'b0, 32'h0, 4'h0, rd);

`ifdef RV0_AHB_SRAM_PARITY_EN
        do_op(0, 32'h20, 3'd2, 1'b1, 32'hA5A50F0F, 4'hF, rd);
        u_dut0.mem[8] = u_dut0.mem[8] ^ 32'h0000_0010;
        xfer(0, 32'h20, 3'd2, 1'b0, 32'h0, 4'h0, rd, err, e1, waits);
        chk("par_err_first", 32'(e1), 32'd1);
        chk("par_err_resp", 32'(err), 32'd1);
        chk("par_err_waits", 32'(waits), 32'd1);
        chk("par_raw_data", rd, 32'hA5A50F1F);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
